pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32 core. Sits beside the `exec` stage and drives the IF/ID/EX pipeline registers and the PC mux. It inserts load-use bubbles, holds the pipeline while a multi-cycle EX operation (mul/div) completes, and turns a taken branch or jump resolved in EX (`addr + offset`) into a registered PC redirect with a wrong-path flush. It also keeps stall and flush performance counters.

---
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle EX holds,
// taken-branch PC redirect with wrong-path flush, and stall/flush counters.
module pipe_ctrl #(
    parameter int MULTI_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_multi,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             misalign,
    output logic             ex_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MULTI, REDIRECT} state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(MULTI_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       branch, aligned, multi_start, load_use;

    assign branch      = ex_valid & ex_taken;
    assign aligned     = (ex_target[1:0] == 2'b00);
    assign multi_start = ex_valid & ex_multi;
    assign load_use    = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (branch) begin
                    if (aligned) state_nxt = REDIRECT;
                end else if (multi_start) begin
                    state_nxt = MULTI;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MULTI: begin
                if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
                else             state_nxt = RUN;
            end
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Outputs are forced low while rst is high so nothing leaks out mid-reset.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        pc_redirect = 1'b0;
        misalign    = 1'b0;
        ex_done     = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (branch) begin
                        if (aligned) begin
                            flush_id  = 1'b1;
                            bubble_ex = 1'b1;
                        end else begin
                            misalign  = 1'b1;
                        end
                    end else if (multi_start) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                MULTI: begin
                    if (cnt != 8'd0) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end else begin
                        ex_done  = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_redirect = 1'b1;
                    flush_id    = 1'b1;
                    bubble_ex   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_target <= 32'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN && branch && aligned) pc_target <= ex_target;
            if (stall_if) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_id) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: cycle-by-cycle model comparison plus literal
// expectations at the key points of each scenario.
module tb_pipe_ctrl;

    localparam int MC    = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_valid, ex_is_load, ex_multi, ex_taken;
    logic [31:0]      ex_target;
    logic             stall_if, stall_id, stall_ex, flush_id, bubble_ex;
    logic             pc_redirect, misalign, ex_done;
    logic [31:0]      pc_target;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.MULTI_CYCLES(MC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_multi(ex_multi), .ex_taken(ex_taken), .ex_target(ex_target),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .misalign(misalign), .ex_done(ex_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: how many more cycles EX is occupied by a multi-cycle op, and
    // whether the next cycle is the redirect cycle of a taken branch.
    int unsigned hold_left;
    bit          redir_now;
    logic [31:0] m_target, m_stalls, m_flushes;
    bit e_sif, e_sid, e_sex, e_fl, e_bub, e_red, e_mis, e_done;
    bit br, hz, start_multi, take_redir;

    always @(negedge clk) begin
        if (checking) begin
            {e_sif, e_sid, e_sex, e_fl, e_bub, e_red, e_mis, e_done} = '0;
            br = ex_valid && ex_taken;
            hz = ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            start_multi = 1'b0;
            take_redir  = 1'b0;
            if (rst) begin
            end else if (redir_now) begin
                e_red = 1; e_fl = 1; e_bub = 1;
            end else if (hold_left > 0) begin
                if (hold_left == 1) e_done = 1;
                else begin e_sif = 1; e_sid = 1; e_sex = 1; end
            end else if (br) begin
                if (ex_target % 4 == 0) begin
                    e_fl = 1; e_bub = 1; take_redir = 1;
                end else e_mis = 1;
            end else if (ex_valid && ex_multi) begin
                e_sif = 1; e_sid = 1; e_sex = 1; start_multi = 1;
            end else if (hz) begin
                e_sif = 1; e_sid = 1; e_bub = 1;
            end
            chk("stall_if",    32'(stall_if),    32'(e_sif));
            chk("stall_id",    32'(stall_id),    32'(e_sid));
            chk("stall_ex",    32'(stall_ex),    32'(e_sex));
            chk("flush_id",    32'(flush_id),    32'(e_fl));
            chk("bubble_ex",   32'(bubble_ex),   32'(e_bub));
            chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
            chk("misalign",    32'(misalign),    32'(e_mis));
            chk("ex_done",     32'(ex_done),     32'(e_done));
            chk("pc_target",   pc_target,        m_target);
            chk("stall_cnt",   stall_cnt,        m_stalls);
            chk("flush_cnt",   flush_cnt,        m_flushes);
            // advance the model across the coming rising edge
            if (rst) begin
                hold_left = 0; redir_now = 0;
                m_target = 0; m_stalls = 0; m_flushes = 0;
            end else begin
                m_stalls  = m_stalls + 32'(e_sif);
                m_flushes = m_flushes + 32'(e_fl);
                if (take_redir) m_target = ex_target;
                redir_now = take_redir;
                if (hold_left > 0) hold_left = hold_left - 1;
                else if (start_multi) hold_left = MC - 1;
            end
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_multi = 0; ex_taken = 0;
        ex_target = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic load_use_vec(input logic [4:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_rs2 = rd; id_use_rs2 = 1;
    endtask

    task automatic branch_vec(input logic [31:0] tgt);
        ex_valid = 1; ex_taken = 1; ex_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1;
        hold_left = 0; redir_now = 0;
        m_target = 0; m_stalls = 0; m_flushes = 0;
        tick();
        checking = 1;
        look();
        chk("rst_stall_if", 32'(stall_if), 32'd0);
        chk("rst_pc_target", pc_target, 32'd0);
        tick();
        load_use_vec(5'd5);             // hazard driven while reset held
        look();
        chk("rst_hold_stall", 32'(stall_if), 32'd0);
        chk("rst_hold_bubble", 32'(bubble_ex), 32'd0);
        tick();
        rst = 0; idle();
        look();
        chk("post_rst_stall_cnt", stall_cnt, 32'd0);
        tick();

        // load-use: exactly one bubble
        load_use_vec(5'd5);
        look();
        chk("lu_stall_if", 32'(stall_if), 32'd1);
        chk("lu_bubble", 32'(bubble_ex), 32'd1);
        tick();
        idle();
        look();
        chk("lu_after_stall", 32'(stall_if), 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        tick();
        load_use_vec(5'd0);
        look();
        chk("lu_x0_stall", 32'(stall_if), 32'd0);
        tick();

        // misaligned taken target: 7 + (-2) = 5
        idle(); branch_vec(32'd7 + 32'hFFFF_FFFE);
        look();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_flush", 32'(flush_id), 32'd0);
        tick();
        idle();
        look();
        chk("mis_gone", 32'(misalign), 32'd0);
        chk("mis_no_redir", 32'(pc_redirect), 32'd0);
        chk("mis_flush_cnt", flush_cnt, 32'd0);
        tick();

        // aligned taken branch
        branch_vec(32'h100);
        look();
        chk("br_flush_t", 32'(flush_id), 32'd1);
        chk("br_no_redir_t", 32'(pc_redirect), 32'd0);
        tick();
        idle();
        look();
        chk("br_redir_t1", 32'(pc_redirect), 32'd1);
        chk("br_target", pc_target, 32'h100);
        chk("br_flush_t1", 32'(flush_id), 32'd1);
        tick();
        look();
        chk("br_redir_t2", 32'(pc_redirect), 32'd0);
        chk("br_flush_cnt", flush_cnt, 32'd2);
        tick();

        // multi-cycle op, ex_multi held through the whole op
        ex_valid = 1; ex_multi = 1;
        for (int i = 0; i < MC; i++) begin
            look();
            chk("mc_stall_ex", 32'(stall_ex), (i < MC - 1) ? 32'd1 : 32'd0);
            chk("mc_ex_done", 32'(ex_done), (i == MC - 1) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        look();
        chk("mc_no_restart", 32'(stall_ex), 32'd0);
        chk("mc_stall_cnt", stall_cnt, 32'd4);
        tick();

        // branch and load-use together: branch wins
        load_use_vec(5'd9); ex_taken = 1; ex_target = 32'h200;
        look();
        chk("both_flush", 32'(flush_id), 32'd1);
        chk("both_bubble", 32'(bubble_ex), 32'd1);
        chk("both_stall_if", 32'(stall_if), 32'd0);
        tick();
        idle();
        look();
        chk("both_redir", 32'(pc_redirect), 32'd1);
        chk("both_target", pc_target, 32'h200);
        tick();

        // reset during MULTI
        ex_valid = 1; ex_multi = 1;
        tick();
        idle(); rst = 1;
        look();
        chk("mrst_stall", 32'(stall_ex), 32'd0);
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mrst_no_done", 32'(ex_done), 32'd0);
            chk("mrst_no_stall", 32'(stall_ex), 32'd0);
            tick();
        end
        look();
        chk("mrst_stall_cnt", stall_cnt, 32'd0);
        tick();

        // reset during REDIRECT
        branch_vec(32'h300);
        tick();
        idle(); rst = 1;
        look();
        chk("rrst_redir", 32'(pc_redirect), 32'd0);
        tick();
        rst = 0;
        look();
        chk("rrst_redir_after", 32'(pc_redirect), 32'd0);
        chk("rrst_target", pc_target, 32'd0);
        chk("rrst_flush_cnt", flush_cnt, 32'd0);
        tick();
        tick();

        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
